// File: rtl/store_align_unit.sv
// store_align_unit: store-side data-memory interface.
// It takes a store (SB/SH/SW, byte address, LSB-justified rs2 data) from execute.
// It aligns the data and byte enables onto the 32-bit bus.
// It then runs a req/gnt write handshake with data memory.
// Build option SA_MISALIGN_SPLIT_EN:
//   - When defined, word-crossing stores are split into two bus beats.
//   - When undefined, misaligned SH/SW stores are rejected with st_err.
module store_align_unit #(
    parameter int REG_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [2:0]         st_type,
    input  logic [REG_LEN-1:0] st_addr,
    input  logic [REG_LEN-1:0] st_data,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic [REG_LEN-1:0] mem_addr,
    output logic [REG_LEN-1:0] mem_wdata,
    output logic [3:0]         mem_be,
    output logic               st_done,
    output logic               st_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Byte-lane footprint of a store type; zero marks an illegal type code.
    function automatic logic [3:0] size_mask(input logic [2:0] t);
        logic [3:0] m;
        case (t)
            3'b000:  m = 4'b0001;
            3'b001:  m = 4'b0011;
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Expand a 4-bit lane mask to a 32-bit data mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    state_t        state_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_be_q;
    logic          st_done_q;
    logic          st_err_q;
`ifdef SA_MISALIGN_SPLIT_EN
    logic          split_q;
    logic [3:0]    be1_q;
    logic [31:0]   wd1_q;
`endif

    logic [1:0]    k_s;
    logic [3:0]    m_s;
    logic [7:0]    be64_s;
    logic [63:0]   wd64_s;
    logic          split_s;
    logic          err_s;

    // Decode the incoming store.
    // Enables and data are shifted across a two-word window: the low word is beat 0, the high word is beat 1.
    always_comb begin
        k_s     = st_addr[1:0];
        m_s     = size_mask(st_type);
        be64_s  = {4'b0000, m_s} << k_s;
        wd64_s  = {32'h0000_0000, st_data & lane_mask(m_s)} << {k_s, 3'b000};
        split_s = |be64_s[7:4];
`ifdef SA_MISALIGN_SPLIT_EN
        err_s   = (m_s == 4'b0000);
`else
        err_s   = (m_s == 4'b0000)
                  || ((st_type == 3'b001) && st_addr[0])
                  || ((st_type == 3'b010) && (k_s != 2'b00));
`endif
    end

`ifndef SA_MISALIGN_SPLIT_EN
    // Second-beat fields are only consumed when splitting is built in.
    logic unused_s;
    assign unused_s = ^{split_s, be64_s[7:4], wd64_s[63:32]};
`endif

    // Store FSM with registered bus and response outputs.
    // The bus fields change only on a state transition, so they stay stable while a beat waits for gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
`ifdef SA_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            be1_q       <= 4'b0000;
            wd1_q       <= 32'h0000_0000;
`endif
        end else begin
            st_done_q <= 1'b0;
            st_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (st_valid) begin
`ifdef SA_MISALIGN_SPLIT_EN
                        split_q <= split_s;
                        be1_q   <= be64_s[7:4];
                        wd1_q   <= wd64_s[63:32];
`endif
                        if (err_s) begin
                            state_q  <= RESP;
                            st_err_q <= 1'b1;
                        end else begin
                            state_q     <= BEAT0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {st_addr[31:2], 2'b00};
                            mem_wdata_q <= wd64_s[31:0];
                            mem_be_q    <= be64_s[3:0];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_gnt) begin
`ifdef SA_MISALIGN_SPLIT_EN
                        if (split_q) begin
                            state_q     <= BEAT1;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_wdata_q <= wd1_q;
                            mem_be_q    <= be1_q;
                        end else begin
                            state_q     <= RESP;
                            mem_req_q   <= 1'b0;
                            mem_addr_q  <= 32'h0000_0000;
                            mem_wdata_q <= 32'h0000_0000;
                            mem_be_q    <= 4'b0000;
                            st_done_q   <= 1'b1;
                        end
`else
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= 32'h0000_0000;
                        mem_wdata_q <= 32'h0000_0000;
                        mem_be_q    <= 4'b0000;
                        st_done_q   <= 1'b1;
`endif
                    end
                end
                BEAT1: begin
                    if (mem_gnt) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        mem_addr_q  <= 32'h0000_0000;
                        mem_wdata_q <= 32'h0000_0000;
                        mem_be_q    <= 4'b0000;
                        st_done_q   <= 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    mem_req_q   <= 1'b0;
                    mem_addr_q  <= 32'h0000_0000;
                    mem_wdata_q <= 32'h0000_0000;
                    mem_be_q    <= 4'b0000;
                end
            endcase
        end
    end

    assign st_ready  = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign st_done   = st_done_q;
    assign st_err    = st_err_q;

endmodule
